// File: rtl/dcache_ctrl_if.sv
// CPU load/store and data-memory signals of the data cache; master = cache controller, slave = CPU + memory side.
// Combinational signalling, no latency; cpu_stall is the only backpressure.
interface dcache_ctrl_if;
    logic [63:0]  cpu_addr;
    logic [63:0]  cpu_wdata;
    logic         cpu_read;
    logic         cpu_write;
    logic [63:0]  cpu_rdata;
    logic         cpu_stall;
    logic [63:0]  mem_addr;
    logic [63:0]  mem_write_data;
    logic         mem_write;
    logic         mem_read;
    logic [127:0] mem_block_data;

    modport master (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_block_data,
        output cpu_rdata, cpu_stall, mem_addr, mem_write_data, mem_write, mem_read
    );

    modport slave (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_block_data,
        input  cpu_rdata, cpu_stall, mem_addr, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through/no-write-allocate D-cache; hits 0 cycles, misses stall MEM_LATENCY+1, stores never stall.
// Optional hit/miss counters under macro DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int NUM_LINES   = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    dcache_ctrl_if.master      bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 60 - IDX_W;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic {S_IDLE, S_REFILL} state_e;

    state_e                 state_q;
    logic [NUM_LINES-1:0]   valid_q;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [127:0]           data_q [NUM_LINES];
    logic [59:0]            blk_q;
    logic [CNT_W-1:0]       cnt_q;
`ifdef DCACHE_STATS_EN
    logic [31:0]            hit_q;
    logic [31:0]            miss_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             idle_rd;
    logic             fill_done;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             unused_addr_bits;

    assign idx       = bus.cpu_addr[4+IDX_W-1:4];
    assign tag       = bus.cpu_addr[63:4+IDX_W];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    // A simultaneous store wins, so only a pure load counts as a read.
    assign idle_rd   = (state_q == S_IDLE) && bus.cpu_read && !bus.cpu_write;
    assign fill_done = (state_q == S_REFILL) && (cnt_q == CNT_W'(MEM_LATENCY - 1));
    assign fill_idx  = blk_q[IDX_W-1:0];
    assign fill_tag  = blk_q[59:IDX_W];
    assign unused_addr_bits = ^bus.cpu_addr[2:0];

    always_comb begin
        bus.cpu_rdata      = '0;
        bus.cpu_stall      = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_addr       = bus.cpu_addr;
        bus.mem_write_data = bus.cpu_wdata;
        if (state_q == S_REFILL) begin
            bus.mem_read  = 1'b1;
            bus.mem_addr  = {blk_q, 4'h0};
            bus.cpu_stall = 1'b1;
        end else if (bus.cpu_write) begin
            bus.mem_write = 1'b1;
        end else if (bus.cpu_read) begin
            if (hit) begin
                bus.cpu_rdata = bus.cpu_addr[3] ? data_q[idx][127:64] : data_q[idx][63:0];
            end else begin
                bus.cpu_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            cnt_q   <= '0;
            blk_q   <= '0;
`ifdef DCACHE_STATS_EN
            hit_q   <= '0;
            miss_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (idle_rd && !hit) begin
                        blk_q   <= bus.cpu_addr[63:4];
                        cnt_q   <= '0;
                        state_q <= S_REFILL;
`ifdef DCACHE_STATS_EN
                        miss_q  <= miss_q + 32'd1;
`endif
                    end
`ifdef DCACHE_STATS_EN
                    if (idle_rd && hit) begin
                        hit_q <= hit_q + 32'd1;
                    end
`endif
                end
                S_REFILL: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (fill_done) begin
                        valid_q[fill_idx] <= 1'b1;
                        state_q           <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line payload needs no reset: valid_q gates every use of it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if ((state_q == S_IDLE) && bus.cpu_write && hit) begin
                if (bus.cpu_addr[3]) begin
                    data_q[idx][127:64] <= bus.cpu_wdata;
                end else begin
                    data_q[idx][63:0] <= bus.cpu_wdata;
                end
            end
            if (fill_done) begin
                data_q[fill_idx] <= bus.mem_block_data;
                tag_q[fill_idx]  <= fill_tag;
            end
        end
    end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller between the CPU load/store path and `data_memory`. It acts as the requesting end of the memory's protocol: it issues 128-bit block reads to refill lines and 64-bit word writes for every store. It stalls the CPU while a refill is in flight.

## Interface
Parameters:
- `NUM_LINES`, 16, number of 16-byte lines; power of 2, >=2. `IDX_W = log2(NUM_LINES)`.
- `MEM_LATENCY`, 1, cycles `mem_read` is held before the block is captured; >=1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cpu_addr`  in  64  byte address; bits [2:0] must be 0.
- `cpu_wdata`  in  64  store data.
- `cpu_read`  in  1  load request.
- `cpu_write`  in  1  store request.
- `cpu_rdata`  out  64  load data; valid when `cpu_read` is high and `cpu_stall` is low.
- `cpu_stall`  out  1  CPU must hold its request and address stable.
- `mem_addr`  out  64  memory address.
- `mem_write_data`  out  64  store data to memory.
- `mem_write`  out  1  word write strobe.
- `mem_read`  out  1  block read enable.
- `mem_block_data`  in  128  combinational block from memory; bytes [addr+15:addr].

## Operation
- Address split: offset `[3:0]`, word select `[3]`, index `[4+IDX_W-1:4]`, tag `[63:4+IDX_W]`.
- Per-line state: `valid`, tag, and a 128-bit data word. The low 64 bits hold word 0.
- A hit requires `valid[index] && tag match`.
- FSM states:
  - IDLE:
    - `cpu_write` forces `mem_write=1`, `mem_addr=cpu_addr`, `mem_write_data=cpu_wdata`, `cpu_stall=0`.
    - On a write hit, the selected 64-bit word of the line is updated at the edge.
    - On a write miss, no line changes.
    - `cpu_read` without `cpu_write`: a hit drives `cpu_rdata` with the selected word and `cpu_stall=0`. A miss sets `cpu_stall=1`, latches block address `{cpu_addr[63:4],4'h0}`, clears the latency counter and moves to REFILL.
  - REFILL:
    - Outputs: `mem_read=1`, `mem_addr=` latched block address, `cpu_stall=1`, `mem_write=0`.
    - The counter increments every cycle.
    - In the cycle where the counter reaches `MEM_LATENCY-1`, `mem_block_data` is captured into the line, tag is written, `valid=1`, and the FSM returns to IDLE.
- `cpu_write` and `cpu_read` asserted together: the write wins and the read is ignored that cycle.
- `cpu_read` dropping during REFILL does not abort the refill.
- `cpu_rdata` is 0 whenever the cycle is not a read hit.
- All outputs are combinational from state and inputs.

## Timing
- Reset (`rst_n=0` at an edge):
  - FSM goes to IDLE; all `valid` bits clear; counter is 0; stats are 0.
  - With idle inputs, outputs are `cpu_stall=0`, `mem_read=0`, `mem_write=0`, `cpu_rdata=0`, `mem_addr=cpu_addr`.
- Reset during REFILL:
  - Next cycle is IDLE with `mem_read=0`.
  - The line being refilled stays invalid.
- Read hit: zero stall, data in the same cycle.
- Read miss: `cpu_stall` high for `MEM_LATENCY+1` cycles (miss-detect cycle plus REFILL cycles). The next cycle is a hit in IDLE; this replay hit counts as a hit.
- Store: one cycle, never stalls. Memory commits at that edge.
- A store issued the cycle after a refill completes sees the refilled line.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `hit_count` (out, 32) and `miss_count` (out, 32), reset to 0, wrapping.
  - `hit_count` increments on every IDLE read hit.
  - `miss_count` increments on every IDLE→REFILL transition.
  - Stores do not count.
- `DCACHE_STATS_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
Memory is preloaded with 50 at 0x10010000, 21 at 0x10010008 and 99 at 0x10010020. Defaults apply unless stated.

1. Cold read: after reset, read 0x10010000.
   - Expect `cpu_stall=1` for 2 cycles, and `mem_read=1` with `mem_addr=0x10010000` in the REFILL cycle.
   - Then `cpu_rdata=50`, `cpu_stall=0`.
   - A read of 0x10010008 on the next cycle hits with 21, `mem_read=0`.
2. Write hit: after scenario 1, write 7 to 0x10010008.
   - Expect a one-cycle `mem_write` with `mem_addr=0x10010008`, data 7, no stall.
   - A following read of 0x10010008 returns 7 with no `mem_read`.
3. Conflict: alternately read 0x10010000 and 0x10010100 (same index 0).
   - Every access misses.
   - Refill addresses are 0x10010000 and 0x10010100 respectively.
4. Write miss: write 5 to uncached 0x10010020.
   - Expect `mem_write`, no stall, line not allocated.
   - The next read of 0x10010020 misses, refills, and returns 5.
5. Reset mid-refill (`MEM_LATENCY=4`): start a read miss and drive `rst_n=0` in the 2nd REFILL cycle.
   - Next cycle: IDLE, `mem_read=0`, `cpu_stall=0` while the read is held low.
   - A re-read misses again and takes a full 5-cycle stall.
6. Stats (`DCACHE_STATS_EN`): run scenario 1 then scenario 4.
   - Expect `hit_count=3` (replay 0x10010000, 0x10010008, replay 0x10010020) and `miss_count=2`.
